// File: rtl/sc_lane_motion_ctrl.sv
// rtl/sc_lane_motion_ctrl.sv - lane row motion controller: init, periodic rotate, reload, pause, stop
// Every output is registered and is decoded from next_state, so it follows the current state.
module sc_lane_motion_ctrl #(
  parameter int LANE_DATAWIDTH  = 8,
  parameter int LANE_PRESCWIDTH = 24,
  parameter int LANE_STEPCYCLES = 3125000
) (
  input  logic                      SC_LaneMotionCtrl_CLOCK_50,
  input  logic                      SC_LaneMotionCtrl_RESET_InHigh,
  input  logic                      SC_LaneMotionCtrl_start_InLow,
  input  logic                      SC_LaneMotionCtrl_stop_InLow,
  input  logic                      SC_LaneMotionCtrl_pause_InHigh,
  input  logic                      SC_LaneMotionCtrl_direction_In,
  input  logic [3:0]                SC_LaneMotionCtrl_speed_In,
  input  logic                      SC_LaneMotionCtrl_reloadreq_InLow,
  input  logic [LANE_DATAWIDTH-1:0] SC_LaneMotionCtrl_pattern_InBUS,
  output logic                      SC_LaneMotionCtrl_clear_OutLow,
  output logic                      SC_LaneMotionCtrl_load_OutLow,
  output logic [1:0]                SC_LaneMotionCtrl_shiftselection_Out,
  output logic [LANE_DATAWIDTH-1:0] SC_LaneMotionCtrl_data_OutBUS,
  output logic                      SC_LaneMotionCtrl_busy_Out,
  output logic [7:0]                SC_LaneMotionCtrl_shiftcount_Out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_SHIFT,
    S_LOAD,
    S_PAUSE
  } state_t;

  localparam logic [LANE_PRESCWIDTH-1:0] STEP = LANE_PRESCWIDTH'(LANE_STEPCYCLES);

  state_t                     state, next_state;
  logic [LANE_PRESCWIDTH-1:0] presc, presc_next;
  logic [LANE_PRESCWIDTH-1:0] period, period_m1;
  logic [7:0]                 count, count_next;
  logic                       clear_next, load_next, busy_next;
  logic [1:0]                 sel_next;
  logic [LANE_DATAWIDTH-1:0]  data_next;
  logic                       tick;

  // A prescaler already past a freshly lowered period fires on the next compare.
  always_comb begin
    period    = LANE_PRESCWIDTH'(5'd16 - {1'b0, SC_LaneMotionCtrl_speed_In}) * STEP;
    period_m1 = period - LANE_PRESCWIDTH'(1);
    tick      = (presc >= period_m1);
  end

  always_comb begin
    next_state = state;
    presc_next = presc;
    count_next = count;
    clear_next = 1'b1;
    load_next  = 1'b1;
    sel_next   = 2'b00;
    data_next  = SC_LaneMotionCtrl_data_OutBUS;
    busy_next  = 1'b1;

    if (!SC_LaneMotionCtrl_start_InLow) begin
      next_state = S_INIT;
      presc_next = '0;
      count_next = '0;
    end else if (!SC_LaneMotionCtrl_stop_InLow) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: next_state = S_IDLE;
        S_INIT: begin
          next_state = S_RUN;
          presc_next = '0;
          count_next = '0;
        end
        S_RUN: begin
          if (!SC_LaneMotionCtrl_reloadreq_InLow) begin
            next_state = S_LOAD;
            presc_next = '0;
          end else if (SC_LaneMotionCtrl_pause_InHigh) begin
            next_state = S_PAUSE;
          end else if (tick) begin
            next_state = S_SHIFT;
            presc_next = '0;
            count_next = count + 8'd1;
          end else begin
            presc_next = presc + LANE_PRESCWIDTH'(1);
          end
        end
        S_SHIFT: begin
          next_state = S_RUN;
          presc_next = presc + LANE_PRESCWIDTH'(1);
        end
        S_LOAD: next_state = S_RUN;
        S_PAUSE: begin
          if (!SC_LaneMotionCtrl_reloadreq_InLow) begin
            next_state = S_LOAD;
            presc_next = '0;
          end else if (!SC_LaneMotionCtrl_pause_InHigh) begin
            next_state = S_RUN;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end

    case (next_state)
      S_IDLE:  busy_next = 1'b0;
      S_INIT:  clear_next = 1'b0;
      S_SHIFT: sel_next = SC_LaneMotionCtrl_direction_In ? 2'b10 : 2'b01;
      S_LOAD: begin
        load_next = 1'b0;
        data_next = SC_LaneMotionCtrl_pattern_InBUS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge SC_LaneMotionCtrl_CLOCK_50 or posedge SC_LaneMotionCtrl_RESET_InHigh) begin
    if (SC_LaneMotionCtrl_RESET_InHigh) begin
      state                                <= S_IDLE;
      presc                                <= '0;
      count                                <= '0;
      SC_LaneMotionCtrl_clear_OutLow       <= 1'b1;
      SC_LaneMotionCtrl_load_OutLow        <= 1'b1;
      SC_LaneMotionCtrl_shiftselection_Out <= 2'b00;
      SC_LaneMotionCtrl_data_OutBUS        <= '0;
      SC_LaneMotionCtrl_busy_Out           <= 1'b0;
    end else begin
      state                                <= next_state;
      presc                                <= presc_next;
      count                                <= count_next;
      SC_LaneMotionCtrl_clear_OutLow       <= clear_next;
      SC_LaneMotionCtrl_load_OutLow        <= load_next;
      SC_LaneMotionCtrl_shiftselection_Out <= sel_next;
      SC_LaneMotionCtrl_data_OutBUS        <= data_next;
      SC_LaneMotionCtrl_busy_Out           <= busy_next;
    end
  end

  assign SC_LaneMotionCtrl_shiftcount_Out = count;

endmodule
